// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared types for the LED pattern generator
package led_pattern_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_t;

endpackage

// File: rtl/led_channel.sv
// rtl/led_channel.sv - one LED channel: mode/period/duty registers, phase counter, blink level
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int PERIOD_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                wr,
  input  logic                restart,
  input  led_mode_t           mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] duty,
  output logic                led
);

  led_mode_t           mode_q, mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] duty_q, duty_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic                level_q, level_d;
  logic                led_q, led_d;

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    phase_d  = phase_q;
    level_d  = level_q;
    led_d    = 1'b0;

    if (wr) begin
      mode_d   = mode;
      period_d = period;
      duty_d   = duty;
    end

    // A write or restart pins the pattern to its start even on a tick cycle
    if (wr || restart) begin
      phase_d = '0;
      level_d = 1'b0;
    end else if (tick) begin
      if (phase_q == period_q) begin
        phase_d = '0;
        if (mode_q == LED_BLINK) level_d = ~level_q;
      end else begin
        phase_d = phase_q + PERIOD_W'(1);
      end
    end

    case (mode_q)
      LED_OFF:   led_d = 1'b0;
      LED_ON:    led_d = 1'b1;
      LED_BLINK: led_d = level_q;
      LED_PWM:   led_d = (phase_q < duty_q);
      default:   led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= LED_OFF;
      period_q <= '0;
      duty_q   <= '0;
      phase_q  <= '0;
      level_q  <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      phase_q  <= phase_d;
      level_q  <= level_d;
      led_q    <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel LED driver: shared prescaler, write decode (LED_SYNC_EN adds sync_restart)
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int PRESCALE_MAX = 49999,
  parameter int PERIOD_W     = 10,
  parameter int CH_W         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                fpga_clk_50,
  input  logic                hps_fpga_reset,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PERIOD_W-1:0] cfg_duty,
`ifdef LED_SYNC_EN
  input  logic                sync_restart,
`endif
  output logic                tick,
  output logic [NUM_LEDS-1:0] LED
);

  localparam int PS_W = (PRESCALE_MAX > 0) ? $clog2(PRESCALE_MAX + 1) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE_MAX);

  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick_q, tick_d;
  logic            restart;
  logic [31:0]     ch_idx;

`ifdef LED_SYNC_EN
  assign restart = sync_restart;
`else
  assign restart = 1'b0;
`endif

  // tick is registered off the next count so it lines up with ps_q == PS_MAX
  always_comb begin
    ps_d = (ps_q == PS_MAX) ? '0 : ps_q + PS_W'(1);
    if (restart) ps_d = '0;
    tick_d = (ps_d == PS_MAX);
  end

  always_ff @(posedge fpga_clk_50) begin
    if (hps_fpga_reset) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      tick_q <= tick_d;
    end
  end

  assign tick   = tick_q;
  assign ch_idx = 32'(cfg_ch);

  // Full-width compare drops writes addressed beyond NUM_LEDS
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_channel #(
      .PERIOD_W(PERIOD_W)
    ) u_ch (
      .clk    (fpga_clk_50),
      .rst    (hps_fpga_reset),
      .tick   (tick_q),
      .wr     (cfg_wr && (ch_idx == i)),
      .restart(restart),
      .mode   (led_mode_t'(cfg_mode)),
      .period (cfg_period),
      .duty   (cfg_duty),
      .led    (LED[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - directed self-checking bench for led_pattern_gen
module tb_led_pattern_gen;

  localparam int TP = 4;

  logic       fpga_clk_50;
  logic       hps_fpga_reset;
  logic       cfg_wr;
  logic [2:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_period;
  logic [3:0] cfg_duty;
`ifdef LED_SYNC_EN
  logic       sync_restart;
`endif
  logic       tick;
  logic [3:0] LED;

  int n_tests;
  int n_fail;
  int c;

  led_pattern_gen #(
    .NUM_LEDS    (4),
    .PRESCALE_MAX(3),
    .PERIOD_W    (4),
    .CH_W        (3)
  ) dut (
    .fpga_clk_50   (fpga_clk_50),
    .hps_fpga_reset(hps_fpga_reset),
    .cfg_wr        (cfg_wr),
    .cfg_ch        (cfg_ch),
    .cfg_mode      (cfg_mode),
    .cfg_period    (cfg_period),
    .cfg_duty      (cfg_duty),
`ifdef LED_SYNC_EN
    .sync_restart  (sync_restart),
`endif
    .tick          (tick),
    .LED           (LED)
  );

  initial fpga_clk_50 = 1'b0;
  always #5 fpga_clk_50 = ~fpga_clk_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, c, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge fpga_clk_50);
    c++;
    check("tick", 32'(tick), (c % TP == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic align(input int r);
    while (c % TP != r) nxt();
  endtask

  task automatic cfg(input logic [2:0] ch, input logic [1:0] mode,
                     input logic [3:0] p, input logic [3:0] d);
    cfg_wr     = 1'b1;
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = p;
    cfg_duty   = d;
    nxt();
    cfg_wr     = 1'b0;
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    c              = 0;
    hps_fpga_reset = 1'b1;
    cfg_wr         = 1'b0;
    cfg_ch         = '0;
    cfg_mode       = '0;
    cfg_period     = '0;
    cfg_duty       = '0;
`ifdef LED_SYNC_EN
    sync_restart   = 1'b0;
`endif
    repeat (3) @(negedge fpga_clk_50);
    check("rst_led", 32'(LED), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    c = 1;
    hps_fpga_reset = 1'b0;
    repeat (12) nxt();

    // ch0 BLINK P=1 written on a tick cycle: 8 low, 8 high, repeating
    align(0);
    cfg(3'd0, 2'd2, 4'd1, 4'd0);
    for (int k = 1; k <= 41; k++) begin
      check("blink0", 32'(LED), (k >= 10 && ((k - 10) / 8) % 2 == 0) ? 32'd1 : 32'd0);
      nxt();
    end

    // ch1 PWM P=3 D=1: high 4 of every 16 cycles
    align(0);
    cfg(3'd1, 2'd3, 4'd3, 4'd1);
    for (int k = 1; k <= 33; k++) begin
      check("pwm_d1", 32'(LED[1]), (k >= 2 && ((k - 2) % 16) < 4) ? 32'd1 : 32'd0);
      nxt();
    end
    cfg(3'd1, 2'd3, 4'd3, 4'd0);
    for (int k = 1; k <= 20; k++) begin
      if (k >= 2) check("pwm_d0", 32'(LED[1]), 32'd0);
      nxt();
    end
    cfg(3'd1, 2'd3, 4'd3, 4'd5);
    for (int k = 1; k <= 20; k++) begin
      if (k >= 2) check("pwm_d5", 32'(LED[1]), 32'd1);
      nxt();
    end

    // back-to-back writes: ch0 OFF, ch1 OFF, ch2 ON
    cfg(3'd0, 2'd0, 4'd0, 4'd0);
    cfg(3'd1, 2'd0, 4'd0, 4'd0);
    cfg(3'd2, 2'd1, 4'd0, 4'd0);
    nxt();
    check("clr", 32'(LED), 32'h4);

    // out-of-range channels would alias onto ch0/ch2/ch3 if truncated
    cfg(3'd4, 2'd1, 4'd0, 4'd0);
    cfg(3'd6, 2'd0, 4'd0, 4'd0);
    cfg(3'd7, 2'd1, 4'd0, 4'd0);
    for (int k = 1; k <= 10; k++) begin
      check("oor", 32'(LED), 32'h4);
      nxt();
    end

    // ch2 BLINK P=0 written on a tick: write wins, then toggles every tick
    align(0);
    cfg(3'd2, 2'd2, 4'd0, 4'd0);
    for (int k = 1; k <= 17; k++) begin
      check("tickwr", 32'(LED),
            (k == 1 || (k >= 2 && ((k - 2) / 4) % 2 == 1)) ? 32'h4 : 32'h0);
      nxt();
    end

    // reset mid-BLINK clears outputs and configuration
    cfg(3'd2, 2'd0, 4'd0, 4'd0);
    align(0);
    cfg(3'd0, 2'd2, 4'd1, 4'd0);
    for (int k = 1; k < 12; k++) nxt();
    check("pre_rst", 32'(LED), 32'h1);
    hps_fpga_reset = 1'b1;
    @(negedge fpga_clk_50);
    check("mid_rst_led", 32'(LED), 32'd0);
    check("mid_rst_tick", 32'(tick), 32'd0);
    c = 1;
    hps_fpga_reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      nxt();
      check("post_rst", 32'(LED), 32'd0);
    end

`ifdef LED_SYNC_EN
    // ch0 and ch1 start 4 cycles apart; sync_restart brings them into step
    align(0);
    cfg(3'd0, 2'd2, 4'd1, 4'd0);
    align(0);
    cfg(3'd1, 2'd2, 4'd1, 4'd0);
    repeat (6) nxt();
    sync_restart = 1'b1;
    @(negedge fpga_clk_50);
    c = 1;
    sync_restart = 1'b0;
    check("sync_tick", 32'(tick), 32'd0);
    for (int k = 2; k <= 26; k++) begin
      nxt();
      check("sync", 32'(LED), (c >= 10 && ((c - 10) / 8) % 2 == 0) ? 32'h3 : 32'h0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised multi-channel LED driver for the HPS/FPGA GHRD fabric: one shared prescaler derives a slow tick from the 50 MHz fabric clock, and each of NUM_LEDS channels independently runs OFF, ON, BLINK or PWM with its own period and duty. Channels are configured through a single-cycle write strobe, typically driven from an HPS-visible register block. Supersedes the fixed single-LED blinker with run-time programmable patterns.

## Interface
- NUM_LEDS, 8, number of independent LED channels (1..32)
- PRESCALE_MAX, 49999, prescaler terminal count; tick period = PRESCALE_MAX+1 clocks (1 ms at 50 MHz)
- PERIOD_W, 10, width of per-channel period/duty fields
- CH_W, $clog2(NUM_LEDS) (min 1), derived channel-select width
- fpga_clk_50  in  1  fabric clock; sole clock
- hps_fpga_reset  in  1  reset, synchronous, active-high
- cfg_wr  in  1  config write strobe, one cycle per write
- cfg_ch  in  CH_W  target channel
- cfg_mode  in  2  0 OFF, 1 ON, 2 BLINK, 3 PWM
- cfg_period  in  PERIOD_W  phase wrap value P (phase counts 0..P)
- cfg_duty  in  PERIOD_W  PWM high count D
- sync_restart  in  1  present only with LED_SYNC_EN
- tick  out  1  one-cycle prescaler pulse, for downstream pacing
- LED  out  NUM_LEDS  LED drive, bit i = channel i

## Operation
- Reset: prescaler 0, tick 0, every channel mode OFF, P=0, D=0, phase 0, blink level 0, LED all 0.
- Prescaler: counts 0..PRESCALE_MAX, wraps to 0; tick=1 exactly in the cycle counter==PRESCALE_MAX.
- Per channel on tick: phase = (phase==P) ? 0 : phase+1. Phase runs in all modes.
- OFF: LED=0. ON: LED=1.
- BLINK: level toggles on tick when phase==P; LED=level; each half-period = (P+1) ticks; P=0 toggles every tick.
- PWM: LED = (phase < D); D=0 constant low; D>P constant high; duty = D/(P+1).
- Config write (cfg_wr=1, cfg_ch<NUM_LEDS): latch mode/P/D, phase←0, level←0 in that channel; other channels untouched.
- cfg_ch >= NUM_LEDS: write ignored, no state change.
- Write and tick same cycle on same channel: write wins (phase 0, no advance, no toggle).
- Reset asserted mid-pattern: all state to reset values next edge; config is lost.

## Timing
- All outputs registered; LED updates one clock after the phase/level/mode change that causes it.
- Write at edge N: new state at N+1, LED reflects new mode at N+2.
- tick registered; tick high for exactly one cycle every PRESCALE_MAX+1 cycles, first at cycle PRESCALE_MAX+1 after reset release.
- No handshake: cfg_wr accepted every cycle, back-to-back writes to any channel legal.

## Configuration
- LED_SYNC_EN defined: sync_restart port exists; when high, prescaler←0 and every channel phase←0, level←0 (config retained), aligning all channels; sync_restart coincident with cfg_wr applies both (write's config, phase 0). Takes precedence over tick.
- LED_SYNC_EN undefined: no sync_restart port, no restart logic; channels align only via individual writes.

## Structure
- Package led_pattern_pkg: led_mode_t enum (LED_OFF, LED_ON, LED_BLINK, LED_PWM), 2-bit.
- Sub-module led_channel: one channel's mode/P/D registers, phase counter, blink level and registered LED bit; instantiated NUM_LEDS times via generate; top holds prescaler and write decode.

## Test plan
- Bench uses PRESCALE_MAX=3, PERIOD_W=4, NUM_LEDS=4.
- Reset release -> LED=0000, tick first high at cycle 4, then every 4 cycles.
- ch0 BLINK P=1 -> LED[0] low 8 cycles, high 8 cycles, repeating; other LEDs stay 0.
- ch1 PWM P=3 D=1 -> LED[1] high 4 of every 16 cycles; D=0 -> always 0; D=5 -> always 1.
- ch2 ON then write cfg_ch=4 (out of range) -> no channel changes; write ch2 on a tick cycle -> phase 0, no toggle.
- Assert reset mid-BLINK -> LED=0000 next cycle, modes OFF; with LED_SYNC_EN, sync_restart mid-pattern -> ch0/ch1 phases both 0, patterns realign.
